// File: rtl/mem_axi_rresp_buf.sv
// Read-response buffer between the memory RX read-data path and an AXI4 R channel.
// First-word-fall-through beat FIFO plus an in-order ARID queue that tags each burst.
module mem_axi_rresp_buf #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int DATA_FIFO_AW   = 2,
    parameter int ID_FIFO_AW     = 2
) (
    input  logic                      mem_clk,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic                      ar_id_push,
    input  logic [AXI_ID_WIDTH-1:0]   ar_id,
    input  logic                      mem_mr_rdata_valid,
    input  logic [AXI_DATA_WIDTH-1:0] mem_mr_rdata,
    input  logic                      mem_mr_rlast,
    input  logic [1:0]                mem_mr_rresp,
    output logic                      mem_mr_rdata_ack,
    output logic                      s_rvalid,
    output logic [AXI_DATA_WIDTH-1:0] s_rdata,
    output logic                      s_rlast,
    output logic [1:0]                s_rresp,
    output logic [AXI_ID_WIDTH-1:0]   s_rid,
    input  logic                      s_rready,
    output logic [DATA_FIFO_AW:0]     data_fifo_level,
    output logic                      id_ovf_err,
    output logic                      id_unf_err
);

    localparam int DATA_DEPTH = 1 << DATA_FIFO_AW;
    localparam int ID_DEPTH   = 1 << ID_FIFO_AW;
    localparam logic [DATA_FIFO_AW:0] D_ONE = 1;
    localparam logic [ID_FIFO_AW:0]   I_ONE = 1;

    typedef struct packed {
        logic                      last;
        logic [1:0]                resp;
        logic [AXI_DATA_WIDTH-1:0] data;
    } beat_t;

    beat_t                    data_mem [DATA_DEPTH];
    logic [AXI_ID_WIDTH-1:0]  id_mem   [ID_DEPTH];

    logic [DATA_FIFO_AW:0] d_wr_q, d_wr_d, d_rd_q, d_rd_d;
    logic [ID_FIFO_AW:0]   i_wr_q, i_wr_d, i_rd_q, i_rd_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;

    logic  data_empty, data_full, id_empty, id_full;
    logic  data_push, r_pop, id_pop, id_push_ok;
    beat_t head;

    always_comb begin
        data_empty = (d_wr_q == d_rd_q);
        data_full  = (d_wr_q[DATA_FIFO_AW] != d_rd_q[DATA_FIFO_AW]) &&
                     (d_wr_q[DATA_FIFO_AW-1:0] == d_rd_q[DATA_FIFO_AW-1:0]);
        id_empty   = (i_wr_q == i_rd_q);
        id_full    = (i_wr_q[ID_FIFO_AW] != i_rd_q[ID_FIFO_AW]) &&
                     (i_wr_q[ID_FIFO_AW-1:0] == i_rd_q[ID_FIFO_AW-1:0]);

        // Ack looks only at registered full, so s_rready never reaches the RX path.
        mem_mr_rdata_ack = mem_mr_rdata_valid && !data_full;
        data_push        = mem_mr_rdata_valid && mem_mr_rdata_ack;

        head     = data_mem[d_rd_q[DATA_FIFO_AW-1:0]];
        s_rvalid = !data_empty && !id_empty;
        s_rdata  = s_rvalid ? head.data : '0;
        s_rlast  = s_rvalid ? head.last : 1'b0;
        s_rresp  = s_rvalid ? head.resp : 2'b00;
        s_rid    = s_rvalid ? id_mem[i_rd_q[ID_FIFO_AW-1:0]] : '0;

        r_pop      = s_rvalid && s_rready;
        id_pop     = r_pop && head.last;
        // A full queue still takes a push when the head burst completes this cycle.
        id_push_ok = ar_id_push && (!id_full || id_pop);

        data_fifo_level = d_wr_q - d_rd_q;
        id_ovf_err      = ovf_q;
        id_unf_err      = unf_q;
    end

    always_comb begin
        d_wr_d = d_wr_q;
        d_rd_d = d_rd_q;
        i_wr_d = i_wr_q;
        i_rd_d = i_rd_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        if (flush) begin
            d_wr_d = '0;
            d_rd_d = '0;
            i_wr_d = '0;
            i_rd_d = '0;
            ovf_d  = 1'b0;
            unf_d  = 1'b0;
        end else begin
            if (data_push)  d_wr_d = d_wr_q + D_ONE;
            if (r_pop)      d_rd_d = d_rd_q + D_ONE;
            if (id_push_ok) i_wr_d = i_wr_q + I_ONE;
            if (id_pop)     i_rd_d = i_rd_q + I_ONE;
            if (ar_id_push && !id_push_ok)               ovf_d = 1'b1;
            if (data_push && mem_mr_rlast && id_empty)   unf_d = 1'b1;
        end
    end

    always_ff @(posedge mem_clk or negedge reset_n) begin
        if (!reset_n) begin
            d_wr_q <= '0;
            d_rd_q <= '0;
            i_wr_q <= '0;
            i_rd_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            d_wr_q <= d_wr_d;
            d_rd_q <= d_rd_d;
            i_wr_q <= i_wr_d;
            i_rd_q <= i_rd_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    // NOTE: storage arrays are not reset; pointers alone define validity and outputs are masked.
    always_ff @(posedge mem_clk) begin
        if (data_push && !flush)
            data_mem[d_wr_q[DATA_FIFO_AW-1:0]] <= '{last: mem_mr_rlast, resp: mem_mr_rresp,
                                                    data: mem_mr_rdata};
        if (id_push_ok && !flush)
            id_mem[i_wr_q[ID_FIFO_AW-1:0]] <= ar_id;
    end

endmodule

// File: tb/tb_mem_axi_rresp_buf.sv
// Directed bench for mem_axi_rresp_buf: latency, backpressure, resp pass-through,
// ID queue overflow/underflow, flush and asynchronous reset.
module tb_mem_axi_rresp_buf;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        ar_id_push;
    logic [3:0]  ar_id;
    logic        mem_mr_rdata_valid;
    logic [31:0] mem_mr_rdata;
    logic        mem_mr_rlast;
    logic [1:0]  mem_mr_rresp;
    logic        mem_mr_rdata_ack;
    logic        s_rvalid;
    logic [31:0] s_rdata;
    logic        s_rlast;
    logic [1:0]  s_rresp;
    logic [3:0]  s_rid;
    logic        s_rready;
    logic [2:0]  data_fifo_level;
    logic        id_ovf_err;
    logic        id_unf_err;

    int n_run  = 0;
    int n_fail = 0;

    mem_axi_rresp_buf dut (
        .mem_clk            (clk),
        .reset_n            (reset_n),
        .flush              (flush),
        .ar_id_push         (ar_id_push),
        .ar_id              (ar_id),
        .mem_mr_rdata_valid (mem_mr_rdata_valid),
        .mem_mr_rdata       (mem_mr_rdata),
        .mem_mr_rlast       (mem_mr_rlast),
        .mem_mr_rresp       (mem_mr_rresp),
        .mem_mr_rdata_ack   (mem_mr_rdata_ack),
        .s_rvalid           (s_rvalid),
        .s_rdata            (s_rdata),
        .s_rlast            (s_rlast),
        .s_rresp            (s_rresp),
        .s_rid              (s_rid),
        .s_rready           (s_rready),
        .data_fifo_level    (data_fifo_level),
        .id_ovf_err         (id_ovf_err),
        .id_unf_err         (id_unf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic beat(input logic v, input logic [31:0] d, input logic l, input logic [1:0] r);
        mem_mr_rdata_valid = v;
        mem_mr_rdata       = d;
        mem_mr_rlast       = l;
        mem_mr_rresp       = r;
    endtask

    task automatic chk_r(input string tag, input logic v, input logic [31:0] d,
                         input logic l, input logic [3:0] id);
        check({tag, ".rvalid"}, 64'(s_rvalid), 64'(v));
        check({tag, ".rdata"},  64'(s_rdata),  64'(d));
        check({tag, ".rlast"},  64'(s_rlast),  64'(l));
        check({tag, ".rid"},    64'(s_rid),    64'(id));
    endtask

    initial begin
        reset_n    = 1'b0;
        flush      = 1'b0;
        ar_id_push = 1'b0;
        ar_id      = 4'd0;
        s_rready   = 1'b0;
        beat(1'b0, 32'h0, 1'b0, 2'b00);
        tick();
        tick();
        chk_r("rst", 1'b0, 32'h0, 1'b0, 4'h0);
        check("rst.ack",   64'(mem_mr_rdata_ack), 64'd0);
        check("rst.resp",  64'(s_rresp),          64'd0);
        check("rst.level", 64'(data_fifo_level),  64'd0);
        check("rst.ovf",   64'(id_ovf_err),       64'd0);
        check("rst.unf",   64'(id_unf_err),       64'd0);
        reset_n = 1'b1;
        tick();

        // Basic 4-beat burst, ID 3, sink always ready
        s_rready = 1'b1; ar_id_push = 1'b1; ar_id = 4'd3;
        beat(1'b1, 32'h11, 1'b0, 2'b00); settle();
        check("t1.ack0", 64'(mem_mr_rdata_ack), 64'd1);
        check("t1.rv0",  64'(s_rvalid), 64'd0);
        tick(); ar_id_push = 1'b0; beat(1'b1, 32'h22, 1'b0, 2'b00); settle();
        chk_r("t1.b1", 1'b1, 32'h11, 1'b0, 4'd3);
        check("t1.lvl1", 64'(data_fifo_level), 64'd1);
        tick(); beat(1'b1, 32'h33, 1'b0, 2'b00); settle();
        chk_r("t1.b2", 1'b1, 32'h22, 1'b0, 4'd3);
        tick(); beat(1'b1, 32'h44, 1'b1, 2'b00); settle();
        chk_r("t1.b3", 1'b1, 32'h33, 1'b0, 4'd3);
        tick(); beat(1'b0, 32'h0, 1'b0, 2'b00); settle();
        chk_r("t1.b4", 1'b1, 32'h44, 1'b1, 4'd3);
        tick();
        check("t1.rv_end",  64'(s_rvalid), 64'd0);
        check("t1.lvl_end", 64'(data_fifo_level), 64'd0);

        // Backpressure: six beats offered into a 4-deep FIFO
        s_rready = 1'b0; ar_id_push = 1'b1; ar_id = 4'd5;
        beat(1'b1, 32'hA1, 1'b0, 2'b00); settle();
        check("t2.ack1", 64'(mem_mr_rdata_ack), 64'd1);
        tick(); ar_id_push = 1'b0; beat(1'b1, 32'hA2, 1'b0, 2'b00); settle();
        chk_r("t2.hold1", 1'b1, 32'hA1, 1'b0, 4'd5);
        check("t2.lvl1", 64'(data_fifo_level), 64'd1);
        tick(); beat(1'b1, 32'hA3, 1'b0, 2'b00); settle();
        check("t2.lvl2", 64'(data_fifo_level), 64'd2);
        tick(); beat(1'b1, 32'hA4, 1'b0, 2'b00); settle();
        check("t2.lvl3", 64'(data_fifo_level), 64'd3);
        check("t2.ack4", 64'(mem_mr_rdata_ack), 64'd1);
        tick(); beat(1'b1, 32'hA5, 1'b0, 2'b00); settle();
        check("t2.lvl4", 64'(data_fifo_level), 64'd4);
        check("t2.ack5", 64'(mem_mr_rdata_ack), 64'd0);
        chk_r("t2.stall1", 1'b1, 32'hA1, 1'b0, 4'd5);
        tick(); settle();
        check("t2.ack5b", 64'(mem_mr_rdata_ack), 64'd0);
        chk_r("t2.stall2", 1'b1, 32'hA1, 1'b0, 4'd5);
        s_rready = 1'b1; settle();
        check("t2.ack_full_pop", 64'(mem_mr_rdata_ack), 64'd0);
        tick(); settle();
        check("t2.lvl_a", 64'(data_fifo_level), 64'd3);
        check("t2.ack5c", 64'(mem_mr_rdata_ack), 64'd1);
        chk_r("t2.d2", 1'b1, 32'hA2, 1'b0, 4'd5);
        tick(); beat(1'b1, 32'hA6, 1'b1, 2'b00); settle();
        check("t2.lvl_b", 64'(data_fifo_level), 64'd3);
        chk_r("t2.d3", 1'b1, 32'hA3, 1'b0, 4'd5);
        tick(); beat(1'b0, 32'h0, 1'b0, 2'b00); settle();
        chk_r("t2.d4", 1'b1, 32'hA4, 1'b0, 4'd5);
        tick(); chk_r("t2.d5", 1'b1, 32'hA5, 1'b0, 4'd5);
        tick(); chk_r("t2.d6", 1'b1, 32'hA6, 1'b1, 4'd5);
        tick();
        check("t2.rv_end",  64'(s_rvalid), 64'd0);
        check("t2.lvl_end", 64'(data_fifo_level), 64'd0);

        // SLVERR on middle beat of a 3-beat burst
        ar_id_push = 1'b1; ar_id = 4'd2;
        beat(1'b1, 32'hB1, 1'b0, 2'b00);
        tick(); ar_id_push = 1'b0; beat(1'b1, 32'hB2, 1'b0, 2'b10); settle();
        check("t3.resp1", 64'(s_rresp), 64'd0);
        check("t3.data1", 64'(s_rdata), 64'hB1);
        tick(); beat(1'b1, 32'hB3, 1'b1, 2'b00); settle();
        check("t3.resp2", 64'(s_rresp), 64'd2);
        check("t3.data2", 64'(s_rdata), 64'hB2);
        tick(); beat(1'b0, 32'h0, 1'b0, 2'b00); settle();
        check("t3.resp3", 64'(s_rresp), 64'd0);
        chk_r("t3.b3", 1'b1, 32'hB3, 1'b1, 4'd2);
        tick();
        check("t3.rv_end", 64'(s_rvalid), 64'd0);

        // ID queue: fill, push+pop at full, then overflow
        s_rready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            ar_id_push = 1'b1; ar_id = 4'(i);
            tick();
        end
        ar_id_push = 1'b0; beat(1'b1, 32'hC1, 1'b1, 2'b00); settle();
        check("t4.ovf_full", 64'(id_ovf_err), 64'd0);
        tick(); beat(1'b0, 32'h0, 1'b0, 2'b00);
        s_rready = 1'b1; ar_id_push = 1'b1; ar_id = 4'd6; settle();
        chk_r("t4.c1", 1'b1, 32'hC1, 1'b1, 4'd1);
        tick(); s_rready = 1'b0; ar_id_push = 1'b0; settle();
        check("t4.no_ovf", 64'(id_ovf_err), 64'd0);
        check("t4.rv_idle", 64'(s_rvalid), 64'd0);
        ar_id_push = 1'b1; ar_id = 4'd9;
        tick(); ar_id_push = 1'b0; settle();
        check("t4.ovf_set", 64'(id_ovf_err), 64'd1);
        s_rready = 1'b1; beat(1'b1, 32'hD2, 1'b1, 2'b00);
        tick(); beat(1'b1, 32'hD3, 1'b1, 2'b00); settle();
        chk_r("t4.d2", 1'b1, 32'hD2, 1'b1, 4'd2);
        tick(); beat(1'b1, 32'hD4, 1'b1, 2'b00); settle();
        chk_r("t4.d3", 1'b1, 32'hD3, 1'b1, 4'd3);
        tick(); beat(1'b1, 32'hD6, 1'b1, 2'b00); settle();
        chk_r("t4.d4", 1'b1, 32'hD4, 1'b1, 4'd4);
        tick(); beat(1'b0, 32'h0, 1'b0, 2'b00); settle();
        chk_r("t4.d6", 1'b1, 32'hD6, 1'b1, 4'd6);
        tick(); beat(1'b1, 32'hE0, 1'b0, 2'b00);
        tick(); beat(1'b0, 32'h0, 1'b0, 2'b00); settle();
        check("t4.dropped_lvl", 64'(data_fifo_level), 64'd1);
        check("t4.dropped_rv",  64'(s_rvalid), 64'd0);
        check("t4.ovf_sticky",  64'(id_ovf_err), 64'd1);
        flush = 1'b1;
        tick(); flush = 1'b0; settle();
        check("t4.flush_lvl", 64'(data_fifo_level), 64'd0);
        check("t4.flush_ovf", 64'(id_ovf_err), 64'd0);

        // Last beat with no ID queued, ID arrives later
        beat(1'b1, 32'h77, 1'b1, 2'b00); settle();
        check("t5.ack", 64'(mem_mr_rdata_ack), 64'd1);
        tick(); beat(1'b0, 32'h0, 1'b0, 2'b00); settle();
        check("t5.unf", 64'(id_unf_err), 64'd1);
        check("t5.rv0", 64'(s_rvalid), 64'd0);
        check("t5.lvl", 64'(data_fifo_level), 64'd1);
        tick(); ar_id_push = 1'b1; ar_id = 4'd7; settle();
        check("t5.rv1", 64'(s_rvalid), 64'd0);
        tick(); ar_id_push = 1'b0; settle();
        chk_r("t5.emit", 1'b1, 32'h77, 1'b1, 4'd7);
        tick();
        check("t5.rv_end", 64'(s_rvalid), 64'd0);
        check("t5.unf_sticky", 64'(id_unf_err), 64'd1);

        // Flush with three beats buffered and R valid
        s_rready = 1'b0; ar_id_push = 1'b1; ar_id = 4'd1;
        beat(1'b1, 32'hF1, 1'b0, 2'b00);
        tick(); ar_id_push = 1'b0; beat(1'b1, 32'hF2, 1'b0, 2'b00);
        tick(); beat(1'b1, 32'hF3, 1'b0, 2'b00);
        tick(); beat(1'b0, 32'h0, 1'b0, 2'b00); settle();
        check("t6.lvl3", 64'(data_fifo_level), 64'd3);
        check("t6.rv1",  64'(s_rvalid), 64'd1);
        flush = 1'b1;
        tick(); flush = 1'b0; beat(1'b1, 32'h61, 1'b0, 2'b00); settle();
        chk_r("t6.post", 1'b0, 32'h0, 1'b0, 4'h0);
        check("t6.lvl0", 64'(data_fifo_level), 64'd0);
        check("t6.unf0", 64'(id_unf_err), 64'd0);
        check("t6.ack",  64'(mem_mr_rdata_ack), 64'd1);
        tick(); beat(1'b0, 32'h0, 1'b0, 2'b00); settle();
        check("t6.lvl1", 64'(data_fifo_level), 64'd1);
        check("t6.rv_noid", 64'(s_rvalid), 64'd0);

        // Asynchronous reset mid-cycle clears immediately
        ar_id_push = 1'b1; ar_id = 4'd8;
        tick(); ar_id_push = 1'b0; settle();
        check("t7.rv_pre", 64'(s_rvalid), 64'd1);
        reset_n = 1'b0; settle();
        check("t7.rv_rst",  64'(s_rvalid), 64'd0);
        check("t7.lvl_rst", 64'(data_fifo_level), 64'd0);
        tick(); reset_n = 1'b1;
        tick();
        check("t7.rv_after", 64'(s_rvalid), 64'd0);
        check("t7.rdata_after", 64'(s_rdata), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
